key_expansion: RTL and testbench

KEY_EXPANSION -- requirements
Module: key_expansion

---
 rtl/key_expansion_if.sv | 57 +++++
 rtl/key_expansion.sv | 269 ++++++++++++++++++++++++++
 tb/tb_key_expansion.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_expansion_if.sv
// ---------------------------------------------------------------------------
// key_expansion_if
//
// Bundles the key-load request and the round-key stream of key_expansion.
//
//   key_in0..key_in15          8  cipher key bytes, byte i = column i/4, row i%4
//   key_valid                  1  start request (sampled in IDLE)
//   round_key_ready            1  downstream stage accepts the presented key
//   round_key_out0..out15      8  presented round key, same byte order as key_in*
//   round_key_valid            1  round_key_out* / round_num are valid
//   round_num                  4  index 0..10 of the presented round key
//   busy                       1  expansion in progress
//   done                       1  one-cycle pulse after round key 10 is taken
//
// Modports:
//   master : the client that loads keys and consumes round keys
//   slave  : the key expansion engine
// ---------------------------------------------------------------------------
interface key_expansion_if;
    logic [7:0] key_in0,  key_in1,  key_in2,  key_in3;
    logic [7:0] key_in4,  key_in5,  key_in6,  key_in7;
    logic [7:0] key_in8,  key_in9,  key_in10, key_in11;
    logic [7:0] key_in12, key_in13, key_in14, key_in15;
    logic       key_valid;
    logic       round_key_ready;

    logic [7:0] round_key_out0,  round_key_out1,  round_key_out2,  round_key_out3;
    logic [7:0] round_key_out4,  round_key_out5,  round_key_out6,  round_key_out7;
    logic [7:0] round_key_out8,  round_key_out9,  round_key_out10, round_key_out11;
    logic [7:0] round_key_out12, round_key_out13, round_key_out14, round_key_out15;
    logic       round_key_valid;
    logic [3:0] round_num;
    logic       busy;
    logic       done;

    modport master (
        output key_in0, key_in1, key_in2, key_in3, key_in4, key_in5, key_in6, key_in7,
               key_in8, key_in9, key_in10, key_in11, key_in12, key_in13, key_in14, key_in15,
               key_valid, round_key_ready,
        input  round_key_out0, round_key_out1, round_key_out2, round_key_out3,
               round_key_out4, round_key_out5, round_key_out6, round_key_out7,
               round_key_out8, round_key_out9, round_key_out10, round_key_out11,
               round_key_out12, round_key_out13, round_key_out14, round_key_out15,
               round_key_valid, round_num, busy, done
    );

    modport slave (
        input  key_in0, key_in1, key_in2, key_in3, key_in4, key_in5, key_in6, key_in7,
               key_in8, key_in9, key_in10, key_in11, key_in12, key_in13, key_in14, key_in15,
               key_valid, round_key_ready,
        output round_key_out0, round_key_out1, round_key_out2, round_key_out3,
               round_key_out4, round_key_out5, round_key_out6, round_key_out7,
               round_key_out8, round_key_out9, round_key_out10, round_key_out11,
               round_key_out12, round_key_out13, round_key_out14, round_key_out15,
               round_key_valid, round_num, busy, done
    );
endinterface

// File: rtl/key_expansion.sv
// ---------------------------------------------------------------------------
// key_expansion
//
// AES-128 key schedule. A key loaded in IDLE is presented as round key 0;
// each accepted round key is replaced by the next one until round key 10
// has been accepted, after which done pulses and the engine returns to IDLE.
//
// Ports:
//   sys_clk  - clock, all state changes on the rising edge
//   sys_rst  - synchronous active-high reset
//   bus      - key_expansion_if.slave (key load request + round-key stream)
//
// Configuration:
//   KEY_EXPANSION_SBOX_REG_EN - when defined, the SubWord result is
//   registered and a one-cycle SUBST state is inserted between round keys
//   (valid drops for that cycle). When undefined, the next key is loaded on
//   the handshake edge itself and the stream has no bubbles.
// ---------------------------------------------------------------------------
module key_expansion (
    input  logic           sys_clk,
    input  logic           sys_rst,
    key_expansion_if.slave bus
);

    localparam logic [3:0] LAST_ROUND = 4'd10;

    // AES forward S-box
    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

`ifdef KEY_EXPANSION_SBOX_REG_EN
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        SUBST   = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1
    } state_t;
`endif

    state_t     state_reg;
    logic [7:0] round_key_reg [16];
    logic [3:0] round_num_reg;
    logic       valid_reg;
    logic       busy_reg;
    logic       done_reg;

    logic [7:0] key_in_bytes [16];
    logic [7:0] sub_word     [4];
    logic [7:0] sub_src      [4];
    logic [7:0] temp_word    [4];
    logic [7:0] next_key     [16];
    logic [7:0] rcon;
    logic       handshake;

`ifdef KEY_EXPANSION_SBOX_REG_EN
    logic [7:0] sub_reg [4];
`endif

    // ------------------------------------------------------------------
    // Flatten the interface key bytes into an indexable array
    // ------------------------------------------------------------------
    assign key_in_bytes[0]  = bus.key_in0;
    assign key_in_bytes[1]  = bus.key_in1;
    assign key_in_bytes[2]  = bus.key_in2;
    assign key_in_bytes[3]  = bus.key_in3;
    assign key_in_bytes[4]  = bus.key_in4;
    assign key_in_bytes[5]  = bus.key_in5;
    assign key_in_bytes[6]  = bus.key_in6;
    assign key_in_bytes[7]  = bus.key_in7;
    assign key_in_bytes[8]  = bus.key_in8;
    assign key_in_bytes[9]  = bus.key_in9;
    assign key_in_bytes[10] = bus.key_in10;
    assign key_in_bytes[11] = bus.key_in11;
    assign key_in_bytes[12] = bus.key_in12;
    assign key_in_bytes[13] = bus.key_in13;
    assign key_in_bytes[14] = bus.key_in14;
    assign key_in_bytes[15] = bus.key_in15;

    assign handshake = valid_reg && bus.round_key_ready;

    // ------------------------------------------------------------------
    // SubWord(RotWord(w3)): lane gi looks up byte 12 + ((gi+1) mod 4),
    // i.e. bytes 13,14,15,12 in that order.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sub
            assign sub_word[gi] = SBOX[round_key_reg[12 + ((gi + 1) % 4)]];
        end
    endgenerate

`ifdef KEY_EXPANSION_SBOX_REG_EN
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sub_src
            assign sub_src[gi] = sub_reg[gi];
        end
    endgenerate
`else
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sub_src
            assign sub_src[gi] = sub_word[gi];
        end
    endgenerate
`endif

    // Round constant for the key being produced (round_num_reg + 1).
    // round_num_reg does not advance until the next key loads, so this is
    // also correct when the SubWord result comes from sub_reg.
    always_comb begin
        rcon = 8'h00;
        case (round_num_reg)
            4'd0:    rcon = 8'h01;
            4'd1:    rcon = 8'h02;
            4'd2:    rcon = 8'h04;
            4'd3:    rcon = 8'h08;
            4'd4:    rcon = 8'h10;
            4'd5:    rcon = 8'h20;
            4'd6:    rcon = 8'h40;
            4'd7:    rcon = 8'h80;
            4'd8:    rcon = 8'h1b;
            4'd9:    rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    // Rcon only touches the row-0 byte
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_temp
            if (gi == 0) begin : g_row0
                assign temp_word[gi] = sub_src[gi] ^ rcon;
            end else begin : g_rown
                assign temp_word[gi] = sub_src[gi];
            end
        end
    endgenerate

    // The chained xor w_c' = w_c ^ w_(c-1)' is unrolled into a prefix xor:
    // byte (col c, row r) of the next key = temp[r] ^ key[0,r] ^ ... ^ key[c,r].
    // This keeps every next_key byte a direct function of registers.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_next
            localparam int COL = gi / 4;
            localparam int ROW = gi % 4;
            assign next_key[gi] = temp_word[ROW]
                                ^ round_key_reg[ROW]
                                ^ ((COL >= 1) ? round_key_reg[4 + ROW]  : 8'h00)
                                ^ ((COL >= 2) ? round_key_reg[8 + ROW]  : 8'h00)
                                ^ ((COL >= 3) ? round_key_reg[12 + ROW] : 8'h00);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_reg     <= IDLE;
            round_num_reg <= 4'd0;
            valid_reg     <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                round_key_reg[i] <= 8'h00;
            end
`ifdef KEY_EXPANSION_SBOX_REG_EN
            for (int i = 0; i < 4; i++) begin
                sub_reg[i] <= 8'h00;
            end
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // done_reg high means this is the cycle right after the
                    // last handshake; a request seen here is dropped.
                    if (bus.key_valid && !done_reg) begin
                        for (int i = 0; i < 16; i++) begin
                            round_key_reg[i] <= key_in_bytes[i];
                        end
                        round_num_reg <= 4'd0;
                        valid_reg     <= 1'b1;
                        busy_reg      <= 1'b1;
                        state_reg     <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (handshake) begin
                        if (round_num_reg == LAST_ROUND) begin
                            valid_reg <= 1'b0;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            state_reg <= IDLE;
                        end else begin
`ifdef KEY_EXPANSION_SBOX_REG_EN
                            for (int i = 0; i < 4; i++) begin
                                sub_reg[i] <= sub_word[i];
                            end
                            valid_reg <= 1'b0;
                            state_reg <= SUBST;
`else
                            for (int i = 0; i < 16; i++) begin
                                round_key_reg[i] <= next_key[i];
                            end
                            round_num_reg <= round_num_reg + 4'd1;
`endif
                        end
                    end
                end
`ifdef KEY_EXPANSION_SBOX_REG_EN
                SUBST: begin
                    for (int i = 0; i < 16; i++) begin
                        round_key_reg[i] <= next_key[i];
                    end
                    round_num_reg <= round_num_reg + 4'd1;
                    valid_reg     <= 1'b1;
                    state_reg     <= PRESENT;
                end
`endif
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.round_key_out0  = round_key_reg[0];
    assign bus.round_key_out1  = round_key_reg[1];
    assign bus.round_key_out2  = round_key_reg[2];
    assign bus.round_key_out3  = round_key_reg[3];
    assign bus.round_key_out4  = round_key_reg[4];
    assign bus.round_key_out5  = round_key_reg[5];
    assign bus.round_key_out6  = round_key_reg[6];
    assign bus.round_key_out7  = round_key_reg[7];
    assign bus.round_key_out8  = round_key_reg[8];
    assign bus.round_key_out9  = round_key_reg[9];
    assign bus.round_key_out10 = round_key_reg[10];
    assign bus.round_key_out11 = round_key_reg[11];
    assign bus.round_key_out12 = round_key_reg[12];
    assign bus.round_key_out13 = round_key_reg[13];
    assign bus.round_key_out14 = round_key_reg[14];
    assign bus.round_key_out15 = round_key_reg[15];
    assign bus.round_key_valid = valid_reg;
    assign bus.round_num       = round_num_reg;
    assign bus.busy            = busy_reg;
    assign bus.done            = done_reg;

endmodule

// File: tb/tb_key_expansion.sv
// ---------------------------------------------------------------------------
// tb_key_expansion
//
// Scoreboard bench for key_expansion. The stimulus process pushes the 11
// expected round keys (from a word-level AES-128 key schedule model whose
// S-box is derived from GF(2^8) inversion + affine map) whenever it issues
// a key that must be accepted. A monitor pops and compares on every
// handshake, checks the done pulse, and checks hold-stability while stalled.
// ---------------------------------------------------------------------------
module tb_key_expansion;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;

    key_expansion_if bus();

    key_expansion dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

`ifdef KEY_EXPANSION_SBOX_REG_EN
    localparam int EXP_SPAN = 21;
`else
    localparam int EXP_SPAN = 11;
`endif

    typedef struct {
        logic [127:0] key;
        int           num;
    } exp_t;

    exp_t         sb_q[$];
    int           checks = 0;
    int           errors = 0;
    logic [7:0]   sbox_m [256];
    logic [127:0] model_keys [11];
    logic [127:0] obs_keys [11];
    bit           random_ready = 1'b0;
    bit           expect_done  = 1'b0;

    // monitor state
    logic [127:0] mon_cur;
    logic [127:0] prev_key;
    logic [3:0]   prev_num;
    bit           prev_stall = 1'b0;
    exp_t         mon_e;

    // ---------------------------------------------------------------
    // Reference model
    // ---------------------------------------------------------------
    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            b = b >> 1;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(logic [7:0] v, int n);
        logic [15:0] t;
        t = {v, v} << n;
        return t[15:8];
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            if (x != 0) begin
                for (int y = 1; y < 256; y++) begin
                    if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
                end
            end
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                            ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic compute_model(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r < 11; r++) begin
            model_keys[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
        end
    endtask

    // ---------------------------------------------------------------
    // Interface helpers
    // ---------------------------------------------------------------
    task automatic drive_key(input logic [127:0] k);
        bus.key_in0  = k[127:120]; bus.key_in1  = k[119:112];
        bus.key_in2  = k[111:104]; bus.key_in3  = k[103:96];
        bus.key_in4  = k[95:88];   bus.key_in5  = k[87:80];
        bus.key_in6  = k[79:72];   bus.key_in7  = k[71:64];
        bus.key_in8  = k[63:56];   bus.key_in9  = k[55:48];
        bus.key_in10 = k[47:40];   bus.key_in11 = k[39:32];
        bus.key_in12 = k[31:24];   bus.key_in13 = k[23:16];
        bus.key_in14 = k[15:8];    bus.key_in15 = k[7:0];
    endtask

    function automatic logic [127:0] read_out();
        return {bus.round_key_out0,  bus.round_key_out1,  bus.round_key_out2,  bus.round_key_out3,
                bus.round_key_out4,  bus.round_key_out5,  bus.round_key_out6,  bus.round_key_out7,
                bus.round_key_out8,  bus.round_key_out9,  bus.round_key_out10, bus.round_key_out11,
                bus.round_key_out12, bus.round_key_out13, bus.round_key_out14, bus.round_key_out15};
    endfunction

    // Issue a key for one cycle; expectations are queued only when the
    // key must be accepted.
    task automatic start_key(input logic [127:0] k);
        drive_key(k);
        bus.key_valid = 1'b1;
        compute_model(k);
        for (int r = 0; r < 11; r++) sb_q.push_back('{key: model_keys[r], num: r});
        @(posedge sys_clk); #1;
        bus.key_valid = 1'b0;
    endtask

    task automatic wait_complete(input string name, input int budget);
        bit ok = 1'b0;
        for (int n = 0; n < budget && !ok; n++) begin
            @(negedge sys_clk); #1;
            if (sb_q.size() == 0 && !bus.busy && !expect_done) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_timeout: %0d keys still pending, busy=%b", name, sb_q.size(), bus.busy);
        end
    endtask

    task automatic wait_round(input string name, input int r);
        bit ok = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge sys_clk); #1;
            if (bus.round_key_valid && bus.round_num == 4'(r)) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_wait_round%0d: round never presented", name, r);
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (read_out() !== 128'h0 || bus.round_num !== 4'd0 || bus.round_key_valid !== 1'b0 ||
            bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL %s: key=%h num=%0d valid=%b busy=%b done=%b, required all zero",
                     name, read_out(), bus.round_num, bus.round_key_valid, bus.busy, bus.done);
        end
    endtask

    task automatic check_key(input string name, input logic [127:0] got, input logic [127:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    // ---------------------------------------------------------------
    // Ready driver
    // ---------------------------------------------------------------
    always @(posedge sys_clk) begin
        #1;
        bus.round_key_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // ---------------------------------------------------------------
    // Monitor / scoreboard
    // ---------------------------------------------------------------
    always @(negedge sys_clk) begin
        mon_cur = read_out();
        if (sys_rst) begin
            prev_stall  = 1'b0;
            expect_done = 1'b0;
        end else begin
            checks++;
            if (bus.done !== expect_done) begin
                errors++;
                $display("FAIL done_pulse: got %b required %b", bus.done, expect_done);
            end
            expect_done = 1'b0;

            if (prev_stall) begin
                checks++;
                if (bus.round_key_valid !== 1'b1 || mon_cur !== prev_key || bus.round_num !== prev_num) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%b num=%0d key=%h required valid=1 num=%0d key=%h",
                             bus.round_key_valid, bus.round_num, mon_cur, prev_num, prev_key);
                end
            end

            if (bus.round_key_valid && bus.round_key_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_handshake: num=%0d key=%h, no key expected",
                             bus.round_num, mon_cur);
                end else begin
                    mon_e = sb_q.pop_front();
                    if (mon_cur !== mon_e.key || bus.round_num !== 4'(mon_e.num)) begin
                        errors++;
                        $display("FAIL round_key: got num=%0d key=%h required num=%0d key=%h",
                                 bus.round_num, mon_cur, mon_e.num, mon_e.key);
                    end else begin
                        $display("round %0d key %h ok", mon_e.num, mon_cur);
                    end
                    obs_keys[mon_e.num] = mon_cur;
                    if (mon_e.num == 10) expect_done = 1'b1;
                end
            end

            prev_stall = bus.round_key_valid && !bus.round_key_ready;
            prev_key   = mon_cur;
            prev_num   = bus.round_num;
        end
    end

    // ---------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------
    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    initial begin
        int span;
        bus.key_valid       = 1'b0;
        bus.round_key_ready = 1'b1;
        drive_key(128'h0);
        build_sbox();
        for (int r = 0; r < 11; r++) obs_keys[r] = 128'h0;

        // Reset state
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk); #1;
        check_zero("reset_state");
        sys_rst = 1'b0;
        @(posedge sys_clk); #1;

        // 1: FIPS key, ready held high, cycle span
        start_key(FIPS_KEY);
        span = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge sys_clk); #1;
            span++;
            if (bus.round_key_valid && bus.round_num == 4'd10) break;
        end
        checks++;
        if (span != EXP_SPAN) begin
            errors++;
            $display("FAIL fips_cycle_span: got %0d cycles required %0d", span, EXP_SPAN);
        end
        wait_complete("fips", 100);
        check_key("fips_round1", obs_keys[1], 128'ha0fafe1788542cb123a339392a6c7605);
        check_key("fips_round10", obs_keys[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        // IDLE keeps the last key and round number
        check_key("idle_hold_key", read_out(), model_keys[10]);
        checks++;
        if (bus.round_num !== 4'd10 || bus.round_key_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold_num: got num=%0d valid=%b required num=10 valid=0",
                     bus.round_num, bus.round_key_valid);
        end

        // 2: same key, ready toggling
        random_ready = 1'b1;
        @(posedge sys_clk); #1;
        for (int r = 0; r < 11; r++) obs_keys[r] = 128'h0;
        start_key(FIPS_KEY);
        wait_complete("fips_random_ready", 400);
        check_key("fips_rr_round10", obs_keys[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Random keys with random ready
        for (int i = 0; i < 4; i++) begin
            @(posedge sys_clk); #1;
            start_key({$urandom, $urandom, $urandom, $urandom});
            wait_complete("random_key", 400);
        end
        random_ready = 1'b0;
        @(posedge sys_clk); #1;

        // 3: all-zero key
        obs_keys[1] = 128'h0;
        start_key(128'h0);
        wait_complete("zero_key", 100);
        check_key("zero_round1", obs_keys[1], 128'h62636363626363636263636362636363);

        // 4: key_valid with a different key at round 4 is ignored
        @(posedge sys_clk); #1;
        start_key(FIPS_KEY);
        wait_round("busy_ignore", 4);
        drive_key(128'h00112233445566778899aabbccddeeff);
        bus.key_valid = 1'b1;
        @(posedge sys_clk); #1;
        bus.key_valid = 1'b0;
        wait_complete("busy_ignore", 100);

        // 5: reset at round 6
        @(posedge sys_clk); #1;
        start_key(128'h000102030405060708090a0b0c0d0e0f);
        wait_round("mid_reset", 6);
        sys_rst = 1'b1;
        sb_q.delete();
        @(posedge sys_clk);
        @(negedge sys_clk); #1;
        check_zero("mid_reset_outputs");
        sys_rst = 1'b0;
        @(posedge sys_clk); #1;
        start_key(128'h000102030405060708090a0b0c0d0e0f);
        wait_complete("after_reset", 100);

        // 6: key_valid during the done cycle is ignored, next cycle accepted
        @(posedge sys_clk); #1;
        start_key(FIPS_KEY);
        wait_round("done_cycle", 10);
        @(posedge sys_clk); #1;
        drive_key(128'hffeeddccbbaa99887766554433221100);
        bus.key_valid = 1'b1;
        @(posedge sys_clk); #1;
        compute_model(128'h3243f6a8885a308d313198a2e0370734);
        drive_key(128'h3243f6a8885a308d313198a2e0370734);
        for (int r = 0; r < 11; r++) sb_q.push_back('{key: model_keys[r], num: r});
        @(negedge sys_clk); #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.round_key_valid !== 1'b0) begin
            errors++;
            $display("FAIL done_cycle_ignore: got busy=%b valid=%b required 0 0",
                     bus.busy, bus.round_key_valid);
        end
        @(posedge sys_clk); #1;
        bus.key_valid = 1'b0;
        wait_complete("after_done_cycle", 100);

        repeat (3) @(posedge sys_clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
